// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM (1-cycle read latency)
// between a sequential display prefetch feeding a show-ahead FIFO and a
// req/ack pixel writer port.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W       = 21,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned FRAME_PIXELS = 1310720,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned LOW_WATER    = 4,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FRAME_START,
  input  logic              PIX_REQ,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              UNDERFLOW,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_ACK,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW  = PtrW + 1;
  localparam int unsigned IssW  = $clog2(FRAME_PIXELS + 1);
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [IssW-1:0]   issued_q;
  logic [WaitW-1:0]  wait_q;
  logic              rd_ret_q;
  logic              underflow_q;
  logic              mem_en_q, mem_we_q, wr_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic        mem_rd, push, pop, disp_el, wr_el, disp_gnt, wr_gnt;
  logic [1:0]  inflight;

  // A display read is outstanding in its access cycle and in its return
  // cycle; both count against free FIFO space so a push can never overflow.
  always_comb begin
    mem_rd   = mem_en_q & ~mem_we_q;
    inflight = {1'b0, mem_rd} + {1'b0, rd_ret_q};
    disp_el  = ((32'(level_q) + 32'(inflight)) < FIFO_DEPTH) &&
               (32'(issued_q) < FRAME_PIXELS) && !FRAME_START;
    wr_el    = WR_REQ & ~wr_ack_q;
    push     = rd_ret_q & ~FRAME_START;
    pop      = PIX_REQ & (level_q != '0) & ~FRAME_START;
    PIX_DATA = (level_q != '0) ? fifo_q[rd_ptr_q] : '0;
  end

  // Grant arbitration: display first below low water, else an aged write wins.
  always_comb begin
    disp_gnt = 1'b0;
    wr_gnt   = 1'b0;
    if (disp_el && wr_el) begin
      if (32'(level_q) < LOW_WATER) begin
        disp_gnt = 1'b1;
      end else if (32'(wait_q) >= MAX_WAIT) begin
        wr_gnt = 1'b1;
      end else begin
        disp_gnt = 1'b1;
      end
    end else begin
      disp_gnt = disp_el;
      wr_gnt   = wr_el;
    end
  end

  // Registered RAM interface, write ack and read-return tag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      rd_ret_q    <= 1'b0;
    end else begin
      mem_en_q    <= disp_gnt | wr_gnt;
      mem_we_q    <= wr_gnt;
      mem_addr_q  <= wr_gnt ? WR_ADDR : (disp_gnt ? rd_addr_q : '0);
      mem_wdata_q <= wr_gnt ? WR_DATA : '0;
      wr_ack_q    <= wr_gnt;
      // Frame start during the access cycle drops that read's data.
      rd_ret_q    <= mem_rd & ~FRAME_START;
    end
  end

  // Prefetch address, per-frame read count and writer wait age.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_addr_q <= '0;
      issued_q  <= '0;
      wait_q    <= '0;
    end else begin
      if (FRAME_START) begin
        rd_addr_q <= '0;
        issued_q  <= '0;
      end else if (disp_gnt) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        issued_q  <= issued_q + IssW'(1);
      end
      if (!WR_REQ || wr_gnt) begin
        wait_q <= '0;
      end else if (32'(wait_q) < MAX_WAIT) begin
        wait_q <= wait_q + WaitW'(1);
      end
    end
  end

  // FIFO pointers, level and sticky underflow; frame start flushes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else if (FRAME_START) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
      if (PIX_REQ && level_q == '0) underflow_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset; the level gates what is visible.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_ptr_q] <= MEM_RDATA;
  end

  assign UNDERFLOW = underflow_q;
  assign WR_ACK    = wr_ack_q;
  assign MEM_EN    = mem_en_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule
